// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared definitions for the instruction fetch sequencer: instruction width,
// the NOP word used whenever inst_code is cleared, the sequencer state
// encoding and a PC word-alignment helper.
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

    localparam int INST_W = 32;

    // Word presented on inst_code whenever the output register is cleared.
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    // Force a byte address onto a 32-bit instruction boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry {valid, data, pc} holding register. It captures a ROM read that
// completes while the decoder is stalled, so that read is not lost, and gives
// it back once the stall releases.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset, empties the entry
//   flush_i  in   discard the entry (redirect); wins over load/drain
//   load_i   in   capture data_i/pc_i and mark the entry valid
//   drain_i  in   the entry is being consumed this cycle; mark it empty
//   data_i   in   instruction word to capture
//   pc_i     in   byte address of data_i
//   vld_o    out  entry holds an instruction
//   data_o   out  held instruction word
//   pc_o     out  held byte address
// -----------------------------------------------------------------------------
module fetch_skid_buf
    import fetch_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic [INST_W-1:0] data_i,
    input  logic [31:0]       pc_i,
    output logic              vld_o,
    output logic [INST_W-1:0] data_o,
    output logic [31:0]       pc_o
);

    logic              vld_q,  vld_d;
    logic [INST_W-1:0] data_q, data_d;
    logic [31:0]       pc_q,   pc_d;

    // Next-state selection for the holding entry.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        pc_d   = pc_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (load_i) begin
            vld_d  = 1'b1;
            data_d = data_i;
            pc_d   = pc_i;
        end else if (drain_i) begin
            vld_d = 1'b0;
        end else begin
            vld_d = vld_q;
        end
    end

    // Entry storage with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= NOP_INST;
            pc_q   <= 32'h0000_0000;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            pc_q   <= pc_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
    assign pc_o   = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the PC and sequences reads from a synchronous instruction ROM, handing
// a registered, PC-tagged instruction stream to the decoder. A read issued in
// cycle n returns data in cycle n+1 and reaches the output register at the
// end of n+1 (two-cycle fetch-to-output latency, one instruction per cycle
// when not stalled). A one-entry skid buffer catches the read that lands
// while the decoder stalls.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   stall          in   decoder cannot accept: hold output, stop issuing
//   redirect_valid in   load redirect_pc into the PC (ignored in BOOT)
//   redirect_pc    in   redirect target byte address
//   halt_req       in   stop fetching (taken in RUN only)
//   rom_en         out  ROM read enable
//   rom_addr       out  ROM word address = pc[ADDR_W+1:2]
//   rom_data       in   ROM read data, valid the cycle after rom_en
//   inst_valid     out  inst_code/inst_pc hold a valid instruction
//   inst_code      out  instruction word
//   inst_pc        out  byte address of inst_code
//   halted         out  sequencer is in HALT
//   misalign       out  sticky: a redirect target had nonzero bits [1:0]
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              halt_req,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_code,
    output logic [31:0]       inst_pc,
    output logic              halted,
    output logic              misalign
);

    fetch_state_e      state_q, state_d;

    logic [31:0]       pc_q,         pc_d;
    logic              req_vld_q,    req_vld_d;
    logic [31:0]       req_pc_q,     req_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic [INST_W-1:0] inst_code_q,  inst_code_d;
    logic [31:0]       inst_pc_q,    inst_pc_d;
    logic              misalign_q,   misalign_d;

    logic              issue_s;
    logic              redir_take_s;
    logic              skid_load_s;
    logic              skid_drain_s;
    logic              skid_vld_s;
    logic [INST_W-1:0] skid_data_s;
    logic [31:0]       skid_pc_s;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect outranks halt, and BOOT ignores both.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    state_d = ST_RUN;
                end else if (halt_req) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Leave only once nothing is in flight or parked, and the last
                // output word is either empty or being taken this cycle.
                if (redirect_valid) begin
                    state_d = ST_RUN;
                end else if (!req_vld_q && !skid_vld_s && (!inst_valid_q || !stall)) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // FSM outputs: ROM issue qualifier and halted flag.
    always_comb begin
        issue_s = 1'b0;
        halted  = 1'b0;
        if (state_q == ST_RUN) begin
            issue_s = !stall && !redirect_valid && !halt_req;
        end else begin
            issue_s = 1'b0;
        end
        if (state_q == ST_HALT) begin
            halted = 1'b1;
        end else begin
            halted = 1'b0;
        end
    end

    assign rom_en   = issue_s;
    assign rom_addr = pc_q[ADDR_W+1:2];

    // ------------------------------------------------------------------
    // Skid buffer control
    // ------------------------------------------------------------------

    // Redirect flushes everything; a stalled returning read parks in the skid,
    // and the skid drains on the first unstalled edge. Load and drain can
    // never coincide: a full skid implies the previous cycle was stalled, so
    // no read is in flight.
    always_comb begin
        redir_take_s = redirect_valid && (state_q != ST_BOOT);
        skid_load_s  = !redir_take_s && stall && req_vld_q;
        skid_drain_s = !redir_take_s && !stall && skid_vld_s;
    end

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redir_take_s),
        .load_i  (skid_load_s),
        .drain_i (skid_drain_s),
        .data_i  (rom_data),
        .pc_i    (req_pc_q),
        .vld_o   (skid_vld_s),
        .data_o  (skid_data_s),
        .pc_o    (skid_pc_s)
    );

    // ------------------------------------------------------------------
    // PC, request tracking and output register
    // ------------------------------------------------------------------

    // Next-state for the PC, in-flight request tag and output register.
    always_comb begin
        pc_d         = pc_q;
        req_vld_d    = 1'b0;
        req_pc_d     = req_pc_q;
        inst_valid_d = inst_valid_q;
        inst_code_d  = inst_code_q;
        inst_pc_d    = inst_pc_q;
        misalign_d   = misalign_q;
        if (redir_take_s) begin
            pc_d         = align_pc(redirect_pc);
            req_vld_d    = 1'b0;
            inst_valid_d = 1'b0;
            inst_code_d  = NOP_INST;
            inst_pc_d    = 32'h0000_0000;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end else begin
                misalign_d = misalign_q;
            end
        end else begin
            if (issue_s) begin
                pc_d      = pc_q + 32'd4;
                req_vld_d = 1'b1;
                req_pc_d  = pc_q;
            end else begin
                req_vld_d = 1'b0;
            end
            // The skid always holds the older instruction, so it goes first.
            if (!stall) begin
                if (skid_vld_s) begin
                    inst_valid_d = 1'b1;
                    inst_code_d  = skid_data_s;
                    inst_pc_d    = skid_pc_s;
                end else if (req_vld_q) begin
                    inst_valid_d = 1'b1;
                    inst_code_d  = rom_data;
                    inst_pc_d    = req_pc_q;
                end else begin
                    inst_valid_d = 1'b0;
                    inst_code_d  = NOP_INST;
                    inst_pc_d    = 32'h0000_0000;
                end
            end else begin
                inst_valid_d = inst_valid_q;
            end
        end
    end

    // PC, request tag, output register and sticky misalign flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            req_vld_q    <= 1'b0;
            req_pc_q     <= 32'h0000_0000;
            inst_valid_q <= 1'b0;
            inst_code_q  <= NOP_INST;
            inst_pc_q    <= 32'h0000_0000;
            misalign_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            req_vld_q    <= req_vld_d;
            req_pc_q     <= req_pc_d;
            inst_valid_q <= inst_valid_d;
            inst_code_q  <= inst_code_d;
            inst_pc_q    <= inst_pc_d;
            misalign_q   <= misalign_d;
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst_code  = inst_code_q;
    assign inst_pc    = inst_pc_q;
    assign misalign   = misalign_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction fetch from the synchronous instruction ROM.
- Owns the PC and drives the ROM address and enable.
- Handles stall, redirect (branch/jump) and halt.
- Delivers a registered, PC-tagged instruction stream to the decoder, with a one-entry skid buffer so a stall loses no in-flight ROM read.

Parameters:
- ADDR_W, 6, ROM word-address width (ROM depth = 2**ADDR_W words).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset.
- stall  input  1  decoder cannot accept; hold output, stop fetching.
- redirect_valid  input  1  one-cycle request to load a new PC.
- redirect_pc  input  32  target PC for redirect.
- halt_req  input  1  request to stop fetching.
- rom_en  output  1  ROM read enable.
- rom_addr  output  ADDR_W  ROM word address = pc[ADDR_W+1:2].
- rom_data  input  32  ROM read data, valid one cycle after rom_en.
- inst_valid  output  1  inst_code/inst_pc hold a valid instruction.
- inst_code  output  32  instruction word.
- inst_pc  output  32  byte address of inst_code.
- halted  output  1  sequencer is in HALT.
- misalign  output  1  sticky: a redirect_pc with nonzero bits [1:0] was received.

Behaviour:
- Reset: rst is asynchronous, active-high.
  - pc=RESET_PC, state=BOOT.
  - rom_en=0, inst_valid=0, inst_code=0, inst_pc=0, halted=0, misalign=0.
  - Internal req_vld and skid_vld cleared.
  - rst asserted mid-operation discards in-flight reads and skid contents immediately.
- States:
  - BOOT: one cycle, no fetch; goes to RUN.
  - RUN: fetching.
  - DRAIN: halt accepted, waiting for in-flight/skid data to be consumed.
  - HALT: halted=1, no fetch.
- rom_en = (state==RUN) && !stall && !redirect_valid && !halt_req. rom_addr is combinational from pc.
- Issue cycle n (rom_en=1):
  - pc<=pc+4 (full 32-bit add; wraps at 2^32).
  - req_vld<=1 and req_pc<=pc; otherwise req_vld<=0.
  - The ROM address wraps modulo 4*2**ADDR_W bytes by truncation.
- Cycle n+1: rom_data belongs to req_pc.
  - If !stall: output register loads the skid entry if skid_vld, else {req_vld, rom_data, req_pc}.
  - If stall: output holds; if req_vld, the entry goes to skid (skid_vld<=1).
- Fetch-to-output latency is 2 cycles. Sustained throughput is 1 instruction/cycle with no stall.
- On stall release there is no bubble: skid drains on the same edge a new read issues.
- The skid is one deep. It cannot overflow because rom_en=0 while stall=1.
- When !stall and nothing is pending, inst_valid<=0.
- redirect_valid (any state except BOOT):
  - pc<={redirect_pc[31:2],2'b00}.
  - req_vld, skid_vld and inst_valid all cleared on that edge, even if stall=1.
  - If redirect_pc[1:0]!=0, misalign<=1 (cleared only by rst).
  - From DRAIN/HALT, go to RUN. The first new instruction appears 2 cycles after the redirect cycle.
- halt_req in RUN (no redirect): go to DRAIN; no further issue.
- DRAIN to HALT: when req_vld=0, skid_vld=0 and (!inst_valid or !stall). The last valid instruction is still delivered.
- Priority on the same edge: rst > redirect_valid > halt_req > stall.

Decomposition:
- Shared package holds:
  - state encoding (BOOT, RUN, DRAIN, HALT);
  - INST_W=32;
  - NOP instruction constant 32'h0000_0000 used for cleared inst_code.
- One sub-module: fetch_skid_buf, the 1-entry {valid, data, pc} holding register with load/drain control.
- PC/FSM logic stays in the top.

Test Plan:
- Reset release, no stall, ROM word k = k:
  - rom_en first high in cycle 2 (BOOT is cycle 1).
  - inst_valid rises in cycle 4 with inst_code=0, inst_pc=0.
  - Then consecutive words 1,2,3… with inst_pc 4,8,12.
- Stall asserted for 3 cycles while inst_pc=8:
  - Outputs hold 8.
  - After release, inst_pc sequence continues 12,16 with no gap or duplicate.
- Redirect to 32'h0000_0040 while stalled with skid full:
  - Next cycle inst_valid=0.
  - Two cycles later inst_pc=0x40, inst_code=word 16.
- Redirect to 32'h0000_0042:
  - misalign=1 and stays 1.
  - Fetch proceeds from 0x40.
- PC wrap: redirect to 0x00FC with ADDR_W=6:
  - inst_pc 0xFC then 0x100.
  - rom_addr 63 then 0.
- halt_req with one read in flight:
  - Last instruction delivered, then halted=1, rom_en=0.
  - Redirect to 0 resumes with inst_pc=0.
  - rst pulse mid-stream clears all outputs asynchronously.
